range_slice_streamer: RTL
=========================

# range_slice_streamer

Bounded append-only buffer with a range-read streamer, sitting directly downstream of the producer that pushes integer samples. Stores pushed values in arrival order and, on request, streams the slice `[start, end]` (inclusive, 0 = oldest entry) out one element per accepted beat over a valid/ready port. It replaces unbounded queue slicing with a synthesizable, backpressured stage.

## Interface
- `DEPTH`, 16: buffer capacity in entries; power of two, at least 2.
- `DATA_W`, 32: sample width.
- `CNT_W`, `$clog2(DEPTH+1)`: width of the occupancy count.
- `clk` in 1: the block's only clock.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: synchronous clear of buffer and streamer.
- `push_valid` in 1: push request.
- `push_data` in DATA_W: value to append; treated as signed.
- `push_ready` out 1: buffer not full.
- `req_valid` in 1: slice request.
- `req_start` in 32: signed slice start index.
- `req_end` in 32: signed slice end index.
- `req_ready` out 1: streamer idle and able to accept a request.
- `req_err` out 1: one-cycle pulse when a request is rejected.
- `out_valid` out 1: slice element available.
- `out_data` out DATA_W: current slice element.
- `out_last` out 1: current element is the final one of the slice.
- `out_ready` in 1: consumer accepts the element.
- `q_size` out CNT_W: registered occupancy.

## Operation
- **Storage:** circular buffer with `wr_ptr` and `count`; `head` stays fixed at 0 until `flush`, so the structure is append-only.
  - Push fires on `push_valid && push_ready`; `push_ready = (count != DEPTH)`.
- **FSM states `IDLE` and `STREAM`:**
  - `IDLE`: `req_ready = !flush`.
  - On `req_valid && req_ready`, the request is valid if `start >= 0`, `end >= 0`, `start <= end` and `end < q_size`. All comparisons are 32-bit signed, with `q_size` zero-extended.
  - A valid request loads `idx = start` and `last_idx = end`, then goes to `STREAM`.
  - An invalid request pulses `req_err` in the next cycle and stays in `IDLE`.
  - `STREAM`: `out_valid = 1`, `out_data = mem[idx]`, `out_last = (idx == last_idx)`.
  - On `out_ready`: if `out_last`, go to `IDLE`; otherwise `idx++`.
  - `out_data` is held stable while `out_valid && !out_ready`.
- **Pushes during `STREAM`** are allowed. They never alter entries `0..q_size-1`, so the active slice is unaffected.
- **`flush`:** sets `count` and `wr_ptr` to 0, aborts `STREAM` to `IDLE` with no `out_last`, and suppresses `req_err`.
- **Simultaneous events:**
  - `flush` with `push`: flush wins and the push is dropped.
  - `push` with `req`: validation uses the pre-push `q_size`.
- **Reset values:** `push_ready=1`, `req_ready=1`, `req_err=0`, `out_valid=0`, `out_last=0`, `out_data=0`, `q_size=0`, state `IDLE`.
- Reset mid-stream returns to reset values immediately, because reset is asynchronous.

## Timing
- Request accepted at edge N: first `out_valid` in cycle N+1.
- With `out_ready` held high, a slice of length L completes in L cycles. The next request can be accepted in the cycle after the `out_last` beat.
- `req_err` is asserted in cycle N+1 for exactly one cycle.
- Push at edge N: `q_size` and `push_ready` update in cycle N+1.
- `out_data` is a combinational read of `mem[idx]`. `idx` and the state are registered.

## Configuration
- `RSS_POS_ONLY_EN`
  - Defined: a push with `push_data <= 0` (signed) is accepted, with `push_ready` honoured, but not stored. `q_size` is unchanged.
  - Undefined: every accepted push is stored.

## Structure
- Package `range_slice_pkg`:
  - state enum `rss_state_e {RSS_IDLE, RSS_STREAM}`;
  - default `DEPTH`/`DATA_W` localparams;
  - a `rss_req_t` struct holding start and end.
- Sub-module `range_slice_mem`: the circular storage array.
  - Write port: `we`, `wr_ptr`, `wdata`.
  - Asynchronous read port: `raddr`, `rdata`.
  - Pointer and count logic stays in the top level.

## Test plan
- **Basic slice:** push 5, 6, 7, 8; request (1,2) with `out_ready=1` → beats 6 then 7 (`out_last` on 7); `q_size=4`; `req_ready` high again the next cycle.
- **Invalid requests:** each of (-1,2), (3,1) and (0,4) with `q_size=4` → `req_err` pulses once; `out_valid` stays 0.
- **Backpressure and concurrent push:** request (0,3) with `out_ready` low for 3 cycles → `out_data=5` held; then push 9 mid-stream → beats 5, 6, 7, 8, with `q_size` reaching 5.
- **Full and flush:** 16 pushes → `push_ready=0` and a 17th push is ignored. `flush` during `STREAM` → `out_valid=0` and `q_size=0` next cycle, with no `out_last`.
- **`RSS_POS_ONLY_EN` defined:** push 3, 0, -2, 4 → `q_size=2`; request (0,1) → beats 3, 4.
- **Async reset mid-stream:** assert `rst` between clock edges → all outputs take their reset values immediately.

Source files
------------

// File: rtl/range_slice_pkg.sv
// +----------------------------------------------------------------------+
// | range_slice_pkg                                                      |
// | Shared types and defaults for the range_slice_streamer block.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package range_slice_pkg;

    localparam int RSS_DEPTH_DEFAULT  = 16;
    localparam int RSS_DATA_W_DEFAULT = 32;

    typedef enum logic [0:0] {
        RSS_IDLE   = 1'b0,
        RSS_STREAM = 1'b1
    } rss_state_e;

    typedef struct packed {
        logic signed [31:0] start_idx;
        logic signed [31:0] end_idx;
    } rss_req_t;

endpackage

`default_nettype wire

// File: rtl/range_slice_mem.sv
// +----------------------------------------------------------------------+
// | range_slice_mem                                                      |
// | Circular sample storage: one synchronous write port and one          |
// | asynchronous read port.                                              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module range_slice_mem
    import range_slice_pkg::*;
#(
    parameter int DEPTH  = RSS_DEPTH_DEFAULT,
    parameter int DATA_W = RSS_DATA_W_DEFAULT,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_ptr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Storage needs no reset: entries beyond the occupancy are never read out.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[wr_ptr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/range_slice_streamer.sv
// +----------------------------------------------------------------------+
// | range_slice_streamer                                                 |
// | Append-only sample buffer that streams an inclusive [start, end]     |
// | slice over a valid/ready port. Optional macro RSS_POS_ONLY_EN drops  |
// | non-positive samples on push.                                        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module range_slice_streamer
    import range_slice_pkg::*;
#(
    parameter int DEPTH  = RSS_DEPTH_DEFAULT,
    parameter int DATA_W = RSS_DATA_W_DEFAULT,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push_valid,
    input  logic [DATA_W-1:0] push_data,
    output logic              push_ready,
    input  logic              req_valid,
    input  logic [31:0]       req_start,
    input  logic [31:0]       req_end,
    output logic              req_ready,
    output logic              req_err,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  q_size
);

    localparam int               c_aw       = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] c_full     = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [c_aw-1:0]  c_idx_one  = c_aw'(1);

    rss_state_e        r_state;
    rss_state_e        w_state_nxt;
    logic [CNT_W-1:0]  r_count;
    logic [c_aw-1:0]   r_wr_ptr;
    logic [c_aw-1:0]   r_idx;
    logic [c_aw-1:0]   w_idx_nxt;
    logic [c_aw-1:0]   r_last_idx;
    logic [c_aw-1:0]   w_last_nxt;
    logic              r_req_err;
    logic              w_err_nxt;
    logic              w_push_fire;
    logic              w_keep;
    logic              w_store;
    logic              w_req_ok;
    logic signed [31:0] w_size_ext;
    logic [DATA_W-1:0] w_rdata;
    rss_req_t          w_req;

    assign push_ready  = (r_count != c_full);
    assign q_size      = r_count;
    assign req_err     = r_req_err;
    assign w_push_fire = push_valid && push_ready && !flush;

`ifdef RSS_POS_ONLY_EN
    assign w_keep = ($signed(push_data) > $signed({DATA_W{1'b0}}));
`else
    assign w_keep = 1'b1;
`endif

    assign w_store = w_push_fire && w_keep;

    // Validation sees the pre-push occupancy, so a same-cycle push never widens the legal range.
    assign w_req.start_idx = req_start;
    assign w_req.end_idx   = req_end;
    assign w_size_ext      = $signed({{(32 - CNT_W){1'b0}}, r_count});
    assign w_req_ok        = (w_req.start_idx >= 0) && (w_req.end_idx >= 0) &&
                             (w_req.start_idx <= w_req.end_idx) &&
                             (w_req.end_idx < w_size_ext);

    range_slice_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (c_aw)
    ) u_mem (
        .clk    (clk),
        .we     (w_store),
        .wr_ptr (r_wr_ptr),
        .wdata  (push_data),
        .raddr  (r_idx),
        .rdata  (w_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= RSS_IDLE;
            r_idx      <= '0;
            r_last_idx <= '0;
            r_req_err  <= 1'b0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_last_idx <= w_last_nxt;
            r_req_err  <= w_err_nxt;
            if (flush) begin
                r_count  <= '0;
                r_wr_ptr <= '0;
            end else if (w_store) begin
                r_count  <= r_count + c_cnt_one;
                r_wr_ptr <= r_wr_ptr + c_idx_one;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_last_nxt  = r_last_idx;
        w_err_nxt   = 1'b0;
        req_ready   = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        out_data    = '0;
        case (r_state)
            RSS_IDLE: begin
                req_ready = !flush;
                if (req_valid && !flush) begin
                    if (w_req_ok) begin
                        w_state_nxt = RSS_STREAM;
                        w_idx_nxt   = w_req.start_idx[c_aw-1:0];
                        w_last_nxt  = w_req.end_idx[c_aw-1:0];
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            RSS_STREAM: begin
                out_valid = 1'b1;
                out_data  = w_rdata;
                out_last  = (r_idx == r_last_idx);
                if (flush) begin
                    w_state_nxt = RSS_IDLE;
                end else if (out_ready) begin
                    if (r_idx == r_last_idx) begin
                        w_state_nxt = RSS_IDLE;
                    end else begin
                        w_idx_nxt = r_idx + c_idx_one;
                    end
                end
            end
            default: begin
                w_state_nxt = RSS_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire
